// File: rtl/rwb_pkg.sv
// Shared types, defaults and the requantisation function for the result write-back stage.
package rwb_pkg;

    localparam int unsigned DEF_LANES      = 8;
    localparam int unsigned DEF_ACC_W      = 32;
    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_ADDR_W     = 16;
    localparam int unsigned DEF_SHIFT_W    = 5;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    // Requant works at a fixed wide precision; callers sign-extend into it and truncate out of it.
    localparam int unsigned RQ_IN_W  = 64;
    localparam int unsigned RQ_OUT_W = 32;

    typedef logic signed [RQ_IN_W:0] rq_wide_t;

    // Buffered beat layout for the default configuration (address plus LANES elements).
    typedef struct packed {
        logic [DEF_ADDR_W-1:0]                    addr;
        logic [DEF_LANES-1:0][DEF_DATA_W-1:0]     data;
    } rwb_entry_t;

    // Shift, optional round-half-up, optional ReLU, then saturate to a signed data_w range.
    function automatic logic signed [RQ_OUT_W-1:0] requant(
        input logic signed [RQ_IN_W-1:0] acc,
        input logic [7:0]                shift,
        input logic                      round_en,
        input logic                      relu_en,
        input int unsigned               data_w
    );
        rq_wide_t x;
        rq_wide_t hi;
        rq_wide_t lo;
        x = rq_wide_t'(acc);
        if (round_en && shift != 8'd0) begin
            x = x + (rq_wide_t'(1) <<< (shift - 8'd1));
        end
        x = x >>> shift;
        if (relu_en && x < rq_wide_t'(0)) begin
            x = rq_wide_t'(0);
        end
        hi = (rq_wide_t'(1) <<< (data_w - 1)) - rq_wide_t'(1);
        lo = -hi - rq_wide_t'(1);
        if (x > hi) begin
            x = hi;
        end else if (x < lo) begin
            x = lo;
        end
        return RQ_OUT_W'(x);
    endfunction

endpackage

// File: rtl/rwb_fifo.sv
// Synchronous FIFO holding requantised beats; DEPTH must be a power of two.
module rwb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rptr];
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/result_writeback.sv
// GEMM result write-back: requantise accumulator beats, buffer them, and serialise to the output SRAM.
module result_writeback
    import rwb_pkg::*;
#(
    parameter int unsigned LANES      = DEF_LANES,
    parameter int unsigned ACC_W      = DEF_ACC_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned SHIFT_W    = DEF_SHIFT_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        cfg_base_addr,
    input  logic [ADDR_W-1:0]        cfg_ch_stride,
    input  logic [ADDR_W-1:0]        cfg_group_stride,
    input  logic [SHIFT_W-1:0]       cfg_shift,
    input  logic                     cfg_round_en,
    input  logic                     cfg_relu_en,
    input  logic                     acc_vld,
    output logic                     acc_rdy,
    input  logic [LANES*ACC_W-1:0]   acc_data,
    input  logic                     acc_kend,
    input  logic                     acc_gend,
    input  logic                     conv_done,
    output logic                     wr_vld,
    input  logic                     wr_rdy,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     done
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned LANE_W = $clog2(LANES);

    typedef struct packed {
        logic [ADDR_W-1:0]              addr;
        logic [LANES-1:0][DATA_W-1:0]   data;
    } entry_t;

    entry_t                        push_entry;
    entry_t                        head;
    logic                          push;
    logic                          pop;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [CNT_W-1:0]              fifo_count;
    logic [ADDR_W-1:0]             tile_base;
    logic [ADDR_W-1:0]             k_base;
    logic [LANE_W-1:0]             lane_cnt;
    logic [LANES-1:0][DATA_W-1:0]  cur_data;
    logic                          last_lane;
    logic                          load;
    logic                          done_pend;

    assign acc_rdy   = !fifo_full;
    assign push      = acc_vld && acc_rdy;
    assign last_lane = (lane_cnt == LANE_W'(LANES - 1));
    assign load      = !wr_vld || (wr_rdy && last_lane);
    assign pop       = load && !fifo_empty;

    // Requantise every lane of the incoming beat and tag it with its base address.
    always_comb begin
        push_entry.addr = k_base;
        push_entry.data = '0;
        for (int i = 0; i < LANES; i++) begin
            push_entry.data[i] = DATA_W'(requant(RQ_IN_W'($signed(acc_data[i*ACC_W +: ACC_W])),
                                                 8'(cfg_shift), cfg_round_en, cfg_relu_en, DATA_W));
        end
    end

    rwb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Address generator: next kernel within a tile, or jump to the next tile / group.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tile_base <= '0;
            k_base    <= '0;
        end else if (start) begin
            tile_base <= cfg_base_addr;
            k_base    <= cfg_base_addr;
        end else if (push) begin
            if (!acc_kend) begin
                k_base <= k_base + cfg_ch_stride;
            end else if (!acc_gend) begin
                tile_base <= tile_base + ADDR_W'(LANES);
                k_base    <= tile_base + ADDR_W'(LANES);
            end else begin
                tile_base <= tile_base + cfg_group_stride;
                k_base    <= tile_base + cfg_group_stride;
            end
        end
    end

    // Serializer: step through lanes of the current beat, reload from the FIFO on the last lane.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_vld   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            lane_cnt <= '0;
            cur_data <= '0;
        end else if (wr_vld && wr_rdy && !last_lane) begin
            lane_cnt <= lane_cnt + LANE_W'(1);
            wr_addr  <= wr_addr + ADDR_W'(1);
            wr_data  <= cur_data[lane_cnt + LANE_W'(1)];
        end else if (load) begin
            if (!fifo_empty) begin
                wr_vld   <= 1'b1;
                wr_addr  <= head.addr;
                wr_data  <= head.data[0];
                lane_cnt <= '0;
                cur_data <= head.data;
            end else begin
                wr_vld <= 1'b0;
            end
        end
    end

    // Completion: remember conv_done, raise done once everything has drained, hold until start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done      <= 1'b0;
            done_pend <= 1'b0;
        end else if (start) begin
            done      <= 1'b0;
            done_pend <= 1'b0;
        end else begin
            if (conv_done && !done) begin
                done_pend <= 1'b1;
            end
            if (done_pend && fifo_count == '0 && !wr_vld) begin
                done      <= 1'b1;
                done_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
// Randomised and directed bench for result_writeback against a behavioural scoreboard.
module tb_result_writeback;

    localparam int unsigned LANES      = 4;
    localparam int unsigned ACC_W      = 32;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned SHIFT_W    = 5;
    localparam int unsigned FIFO_DEPTH = 4;

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic                    start = 1'b0;
    logic [ADDR_W-1:0]       cfg_base_addr = '0;
    logic [ADDR_W-1:0]       cfg_ch_stride = '0;
    logic [ADDR_W-1:0]       cfg_group_stride = '0;
    logic [SHIFT_W-1:0]      cfg_shift = '0;
    logic                    cfg_round_en = 1'b0;
    logic                    cfg_relu_en = 1'b0;
    logic                    acc_vld = 1'b0;
    logic                    acc_rdy;
    logic [LANES*ACC_W-1:0]  acc_data = '0;
    logic                    acc_kend = 1'b0;
    logic                    acc_gend = 1'b0;
    logic                    conv_done = 1'b0;
    logic                    wr_vld;
    logic                    wr_rdy = 1'b0;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic                    done;

    result_writeback #(
        .LANES      (LANES),
        .ACC_W      (ACC_W),
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .SHIFT_W    (SHIFT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .start            (start),
        .cfg_base_addr    (cfg_base_addr),
        .cfg_ch_stride    (cfg_ch_stride),
        .cfg_group_stride (cfg_group_stride),
        .cfg_shift        (cfg_shift),
        .cfg_round_en     (cfg_round_en),
        .cfg_relu_en      (cfg_relu_en),
        .acc_vld          (acc_vld),
        .acc_rdy          (acc_rdy),
        .acc_data         (acc_data),
        .acc_kend         (acc_kend),
        .acc_gend         (acc_gend),
        .conv_done        (conv_done),
        .wr_vld           (wr_vld),
        .wr_rdy           (wr_rdy),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .done             (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state: expected element stream plus address bookkeeping.
    logic [ADDR_W-1:0] m_tile = '0;
    logic [ADDR_W-1:0] m_k    = '0;
    int exp_addr[$];
    int exp_data[$];
    int got_addr[$];
    int got_data[$];
    int got_cyc[$];
    int acc_cyc[$];
    int done_rise = -1;
    logic done_q = 1'b0;
    logic prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DATA_W-1:0] prev_data = '0;

    int rq_exp [3][4] = '{'{127, -3, 3, -128}, '{127, -2, 4, -128}, '{127, 0, 3, 0}};
    int addr_base [5] = '{0, 16, 4, 20, 32};
    logic addr_kend [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic addr_gend [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Requant rule computed on plain 64-bit integers.
    function automatic int ref_requant(input longint acc, input int sh, input bit rnd, input bit relu);
        longint x;
        x = acc;
        if (rnd && sh != 0) x = x + (longint'(1) << (sh - 1));
        x = x >>> sh;
        if (relu && x < 0) x = 0;
        if (x > 127) x = 127;
        if (x < -128) x = -128;
        return int'(x);
    endfunction

    function automatic logic [LANES*ACC_W-1:0] pack4(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    function automatic logic [LANES*ACC_W-1:0] rand_beat();
        logic [LANES*ACC_W-1:0] v;
        int s;
        for (int i = 0; i < LANES; i++) begin
            case ($urandom % 4)
                0: s = int'($urandom);
                1: s = int'($urandom_range(0, 1000)) - 500;
                2: s = int'($urandom_range(0, 8000)) - 4000;
                default: s = int'($urandom_range(0, 600000)) - 300000;
            endcase
            v[i*ACC_W +: ACC_W] = 32'(s);
        end
        return v;
    endfunction

    function automatic int got_addr_at(input int idx);
        return (idx < got_addr.size()) ? got_addr[idx] : -99999;
    endfunction

    function automatic int got_data_at(input int idx);
        return (idx < got_data.size()) ? got_data[idx] : -99999;
    endfunction

    function automatic int got_cyc_at(input int idx);
        return (idx < got_cyc.size()) ? got_cyc[idx] : -99999;
    endfunction

    // Input side of the model: start, reset and accepted beats.
    always @(negedge clk) begin : acc_mon
        logic [ADDR_W-1:0] step;
        if (!rstn) begin
            m_tile = '0;
            m_k    = '0;
            exp_addr.delete();
            exp_data.delete();
        end else if (start) begin
            assert (exp_addr.size() == 0 && !wr_vld) else $error("start issued with data still buffered");
            m_tile = cfg_base_addr;
            m_k    = cfg_base_addr;
        end else if (acc_vld && acc_rdy) begin
            acc_cyc.push_back(cyc);
            for (int i = 0; i < LANES; i++) begin
                exp_addr.push_back(int'(ADDR_W'(m_k + ADDR_W'(i))));
                exp_data.push_back(ref_requant(longint'($signed(acc_data[i*ACC_W +: ACC_W])),
                                               int'(cfg_shift), cfg_round_en, cfg_relu_en));
            end
            if (!acc_kend) begin
                m_k = m_k + cfg_ch_stride;
            end else begin
                step   = acc_gend ? cfg_group_stride : ADDR_W'(LANES);
                m_tile = m_tile + step;
                m_k    = m_tile;
            end
        end
    end

    // Output side: score each written element and watch port stability under stall.
    always @(negedge clk) begin : out_mon
        int ea;
        int ed;
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_vld", wr_vld, 1);
                check("hold_addr", wr_addr, prev_addr);
                check("hold_data", wr_data, prev_data);
            end
            if (wr_vld && wr_rdy) begin
                got_addr.push_back(int'(wr_addr));
                got_data.push_back(int'($signed(wr_data)));
                got_cyc.push_back(cyc);
                if (exp_addr.size() == 0) begin
                    check("spurious_elem", 1, 0);
                end else begin
                    ea = exp_addr.pop_front();
                    ed = exp_data.pop_front();
                    check("wr_addr", wr_addr, ea);
                    check("wr_data", $signed(wr_data), ed);
                end
            end
            prev_stall = wr_vld && !wr_rdy;
            prev_addr  = wr_addr;
            prev_data  = wr_data;
        end
    end

    always @(negedge clk) begin
        if (rstn && done && !done_q) done_rise = cyc;
        done_q = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] cs, input logic [ADDR_W-1:0] gs);
        tick();
        cfg_base_addr    = base;
        cfg_ch_stride    = cs;
        cfg_group_stride = gs;
        start            = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [LANES*ACC_W-1:0] d, input logic k, input logic g, input logic cd);
        bit ok;
        ok        = 1'b0;
        acc_data  = d;
        acc_kend  = k;
        acc_gend  = g;
        conv_done = cd;
        acc_vld   = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (acc_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        acc_vld   = 1'b0;
        conv_done = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (exp_addr.size() == 0 && !wr_vld) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        if (!ok) check("drain_timeout", 0, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int na;
        int n1;

        #2;
        check("rst_wr_vld", wr_vld, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_done", done, 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("rst_acc_rdy", acc_rdy, 1);
        tick();

        // Requant corner values, plus first-element latency from idle.
        wr_rdy = 1'b1;
        for (int m = 0; m < 3; m++) begin
            cfg_shift    = SHIFT_W'(1);
            cfg_round_en = (m == 1);
            cfg_relu_en  = (m == 2);
            start_op(16'd0, 16'd16, 16'd28);
            n0 = got_data.size();
            na = acc_cyc.size();
            send_beat(pack4(300, -5, 7, -400), 1'b0, 1'b0, 1'b0);
            wait_drain();
            for (int i = 0; i < 4; i++) check("requant", got_data_at(n0 + i), rq_exp[m][i]);
            if (m == 0) check("latency", got_cyc_at(n0) - acc_cyc[na], 2);
        end

        // Address pattern across kernel, tile and group boundaries.
        cfg_shift    = '0;
        cfg_round_en = 1'b0;
        cfg_relu_en  = 1'b0;
        start_op(16'd0, 16'd16, 16'd28);
        n0 = got_addr.size();
        for (int b = 0; b < 5; b++) send_beat(rand_beat(), addr_kend[b], addr_gend[b], 1'b0);
        wait_drain();
        for (int b = 0; b < 5; b++)
            for (int i = 0; i < 4; i++) check("addr_seq", got_addr_at(n0 + 4*b + i), addr_base[b] + i);

        // Backpressure: one beat in the serializer plus a full FIFO, then release.
        wr_rdy = 1'b0;
        start_op(16'd0, 16'd16, 16'd28);
        n0 = got_addr.size();
        na = acc_cyc.size();
        acc_kend = 1'b0;
        acc_gend = 1'b0;
        for (int c = 0; c < 12; c++) begin
            acc_data = rand_beat();
            acc_vld  = 1'b1;
            tick();
        end
        @(negedge clk);
        check("bp_acc_rdy", acc_rdy, 0);
        check("bp_beats", acc_cyc.size() - na, 5);
        check("bp_no_out", got_addr.size() - n0, 0);
        tick();
        acc_vld = 1'b0;
        wr_rdy  = 1'b1;
        wait_drain();
        check("bp_elems", got_addr.size() - n0, 20);

        // Throughput: three back-to-back beats stream out without a gap.
        n0 = got_addr.size();
        na = acc_cyc.size();
        for (int b = 0; b < 3; b++) send_beat(rand_beat(), 1'b0, 1'b0, 1'b0);
        wait_drain();
        check("tp_latency", got_cyc_at(n0) - acc_cyc[na], 2);
        check("tp_span", got_cyc_at(n0 + 11) - got_cyc_at(n0), 11);
        check("tp_count", got_addr.size() - n0, 12);

        // Done: conv_done with the last beat; done follows the first idle cycle after the final write.
        start_op(16'd0, 16'd16, 16'd28);
        n0 = got_addr.size();
        send_beat(rand_beat(), 1'b0, 1'b0, 1'b0);
        send_beat(rand_beat(), 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("done_early", done, 0);
        tick();
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (done) break;
        end
        tick();
        check("done_lat", done_rise - got_cyc_at(n0 + 7), 2);
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        @(negedge clk);
        check("done_hold", done, 1);
        start_op(16'd100, 16'd16, 16'd28);
        @(negedge clk);
        check("done_clr", done, 0);
        tick();
        n1 = got_addr.size();
        send_beat(rand_beat(), 1'b0, 1'b0, 1'b0);
        wait_drain();
        check("new_base_lo", got_addr_at(n1), 100);
        check("new_base_hi", got_addr_at(n1 + 3), 103);

        // Reset while two beats are buffered and the port is stalled.
        wr_rdy = 1'b0;
        start_op(16'd0, 16'd16, 16'd28);
        send_beat(rand_beat(), 1'b0, 1'b0, 1'b0);
        send_beat(rand_beat(), 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        rstn = 1'b0;
        #1;
        check("mrst_wr_vld", wr_vld, 0);
        check("mrst_wr_addr", wr_addr, 0);
        check("mrst_wr_data", wr_data, 0);
        check("mrst_done", done, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        wr_rdy = 1'b1;
        n0 = got_addr.size();
        repeat (10) @(negedge clk);
        check("mrst_no_stale", got_addr.size() - n0, 0);
        check("mrst_acc_rdy", acc_rdy, 1);
        check("mrst_idle", wr_vld, 0);
        tick();

        // Random traffic with random strides (address wrap), config and backpressure.
        start_op(ADDR_W'($urandom), ADDR_W'($urandom), ADDR_W'($urandom));
        for (int c = 0; c < 800; c++) begin
            if (c % 64 == 0) begin
                cfg_shift    = SHIFT_W'($urandom);
                cfg_round_en = 1'($urandom);
                cfg_relu_en  = 1'($urandom);
            end
            acc_vld  = ($urandom % 3) != 0;
            acc_data = rand_beat();
            acc_kend = 1'($urandom);
            acc_gend = 1'($urandom);
            wr_rdy   = ($urandom % 4) != 0;
            tick();
        end
        acc_vld = 1'b0;
        wr_rdy  = 1'b1;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
